// File: rtl/store_fence_sequencer_pkg.sv
// Shared types and constants for the store/fence sequencer: FSM states,
// FENCE predecessor bit positions, fence-mode encodings and the drain-mask helper.
package store_fence_sequencer_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DRAIN      = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } seq_state_t;

    // Positions inside {PI,PO,PR,PW,SI,SO,SR,SW}.
    localparam int FENCE_PO = 6;
    localparam int FENCE_PW = 4;

    localparam logic [3:0] FM_NORMAL = 4'b0000;
    localparam logic [3:0] FM_TSO    = 4'b1000;

    // TSO and reserved modes deliberately share the conservative predecessor-write drain.
    function automatic logic [7:0] drain_mask(input logic [3:0] fm);
        logic [7:0] mask;
        mask           = 8'h00;
        mask[FENCE_PO] = 1'b1;
        mask[FENCE_PW] = 1'b1;
        case (fm)
            FM_NORMAL: drain_mask = mask;
            FM_TSO:    drain_mask = mask;
            default:   drain_mask = mask;
        endcase
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Store buffer: DEPTH entries of {addr,data,strb}, head entry presented directly.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module store_fifo #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_addr,
    input  logic [XLEN-1:0] push_data,
    input  logic [7:0]      push_strb,
    output logic [XLEN-1:0] head_addr,
    output logic [XLEN-1:0] head_data,
    output logic [7:0]      head_strb,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0]     wr_ptr_r;
    logic [AW:0]     rd_ptr_r;
    logic [XLEN-1:0] addr_mem_r [DEPTH];
    logic [XLEN-1:0] data_mem_r [DEPTH];
    logic [7:0]      strb_mem_r [DEPTH];

    // Pointer advance and entry storage; contents are cleared on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {XLEN{1'b0}};
                data_mem_r[i] <= {XLEN{1'b0}};
                strb_mem_r[i] <= 8'h00;
            end
        end else begin
            if (push) begin
                addr_mem_r[wr_ptr_r[AW-1:0]] <= push_addr;
                data_mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                strb_mem_r[wr_ptr_r[AW-1:0]] <= push_strb;
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    assign head_addr = addr_mem_r[rd_ptr_r[AW-1:0]];
    assign head_data = data_mem_r[rd_ptr_r[AW-1:0]];
    assign head_strb = strb_mem_r[rd_ptr_r[AW-1:0]];
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

endmodule

// File: rtl/store_fence_sequencer.sv
// Buffers stores, issues them over valid/ready, counts unacked writes and
// sequences FENCE drains and the EBREAK drain-then-halt.
module store_fence_sequencer
    import store_fence_sequencer_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st_valid_in,
    output logic            st_ready_out,
    input  logic [XLEN-1:0] st_addr_in,
    input  logic [XLEN-1:0] st_data_in,
    input  logic [7:0]      st_strb_in,
    input  logic            fence_req_in,
    input  logic [7:0]      fence_sig_in,
    input  logic [3:0]      fence_mode_in,
    input  logic            ebreak_set_in,
    output logic            mem_valid_out,
    input  logic            mem_ready_in,
    output logic [XLEN-1:0] mem_addr_out,
    output logic [XLEN-1:0] mem_data_out,
    output logic [7:0]      mem_strb_out,
    input  logic            mem_ack_in,
    output logic            stall_out,
    output logic            fence_done_out,
    output logic            halted_out,
    output logic            ack_err_out
);

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUT);

    seq_state_t    state_r;
    seq_state_t    state_next_s;
    logic [CW-1:0] out_cnt_r;
    logic [CW-1:0] out_cnt_next_s;
    logic          ack_err_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;
    logic          ack_ok_s;
    logic          drain_fence_s;
    logic          drained_s;
    logic          running_s;

    assign running_s     = (state_r == RUN);
    assign drain_fence_s = |(fence_sig_in & drain_mask(fence_mode_in));
    assign st_ready_out  = ~full_s & running_s & ~fence_req_in;
    assign push_s        = st_valid_in & st_ready_out;
    assign mem_valid_out = ~empty_s & (out_cnt_r < CNT_MAX);
    assign pop_s         = mem_valid_out & mem_ready_in;
    assign ack_ok_s      = mem_ack_in & (out_cnt_r != CNT_ZERO);
    // Drain completes in the cycle whose ack retires the last write.
    assign drained_s     = empty_s & (out_cnt_next_s == CNT_ZERO);
    assign halted_out    = (state_r == HALTED);
    assign ack_err_out   = ack_err_r;

    store_fifo #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_store_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .pop       (pop_s),
        .push_addr (st_addr_in),
        .push_data (st_data_in),
        .push_strb (st_strb_in),
        .head_addr (mem_addr_out),
        .head_data (mem_data_out),
        .head_strb (mem_strb_out),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Outstanding-write count: issue adds one, accepted ack removes one.
    always_comb begin
        out_cnt_next_s = out_cnt_r;
        case ({pop_s, ack_ok_s})
            2'b10:   out_cnt_next_s = out_cnt_r + CNT_ONE;
            2'b01:   out_cnt_next_s = out_cnt_r - CNT_ONE;
            default: out_cnt_next_s = out_cnt_r;
        endcase
    end

    // Next state, stall and fence retirement.
    always_comb begin
        state_next_s   = state_r;
        fence_done_out = 1'b0;
        stall_out      = 1'b1;
        case (state_r)
            RUN: begin
                stall_out = fence_req_in & drain_fence_s;
                if (ebreak_set_in) begin
                    state_next_s = HALT_DRAIN;
                end else if (fence_req_in) begin
                    if (drain_fence_s) begin
                        state_next_s = DRAIN;
                    end else begin
                        fence_done_out = 1'b1;
                    end
                end else begin
                    state_next_s = RUN;
                end
            end
            DRAIN: begin
                if (drained_s) begin
                    state_next_s   = RUN;
                    fence_done_out = 1'b1;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            HALT_DRAIN: begin
                if (drained_s) begin
                    state_next_s = HALTED;
                end else begin
                    state_next_s = HALT_DRAIN;
                end
            end
            HALTED:  state_next_s = HALTED;
            default: state_next_s = RUN;
        endcase
    end

    // State, counter and sticky ack-error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= RUN;
            out_cnt_r <= CNT_ZERO;
            ack_err_r <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            out_cnt_r <= out_cnt_next_s;
            if (mem_ack_in && (out_cnt_r == CNT_ZERO)) begin
                ack_err_r <= 1'b1;
            end
        end
    end

endmodule
